// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts ALU commands, issues them one at a time to an
// external ALU, waits (bounded by TIMEOUT) for the result and buffers the
// responses in a small FIFO. Illegal opcodes (14/15) and ALU timeouts produce
// error responses.
// Optional statistics counters are built when ALU_ISSUER_STATS_EN is defined.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_cin,
  input  logic [3:0] cmd_ctl,
  output logic       alu_valid_in,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [3:0] alu_ctl,
  input  logic       alu_valid_out,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [3:0] rsp_ctl,
  output logic       busy
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [7:0] stat_issued,
  output logic [7:0] stat_errors,
  output logic [7:0] stat_stray
`endif
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]     TMO_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic [3:0] ctl;
    logic       err;
  } rsp_t;

  state_t        state_q, state_d;
  logic [3:0]    timer_q, timer_d;
  logic [3:0]    a_q, a_d, b_q, b_d, ctl_q, ctl_d;
  logic          cin_q, cin_d;
  logic          init_q, init_d;
  rsp_t          mem_q [FIFO_DEPTH];
  rsp_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic accept, legal, push, pop;
  rsp_t push_data, head;

  assign legal  = (cmd_ctl <= 4'd13);
  assign accept = cmd_valid && cmd_ready;
  assign pop    = rsp_valid && rsp_ready;

  // State register and all datapath flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      cin_q   <= 1'b0;
      init_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      cin_q   <= cin_d;
      init_q  <= init_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state logic and WAIT timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (accept && legal) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (alu_valid_out || timer_q == TMO_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // FSM outputs: handshakes and the response pushed this cycle
  always_comb begin
    // cmd_ready stays low until the first edge after reset release
    cmd_ready    = init_q && (state_q == S_IDLE) && (cnt_q < DEPTH_C);
    alu_valid_in = (state_q == S_ISSUE);
    busy         = (state_q != S_IDLE);
    push         = 1'b0;
    push_data    = '0;
    case (state_q)
      S_IDLE: begin
        // illegal opcodes never reach the ALU; answer immediately with err
        if (accept && !legal) begin
          push          = 1'b1;
          push_data.ctl = cmd_ctl;
          push_data.err = 1'b1;
        end
      end
      S_WAIT: begin
        if (alu_valid_out) begin
          push             = 1'b1;
          push_data.result = alu_result;
          push_data.carry  = alu_carry;
          push_data.zero   = alu_zero;
          push_data.ctl    = ctl_q;
        end else if (timer_q == TMO_LAST) begin
          push          = 1'b1;
          push_data.ctl = ctl_q;
          push_data.err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request latch and response FIFO next values
  always_comb begin
    init_d = 1'b1;
    a_d    = a_q;
    b_d    = b_q;
    cin_d  = cin_q;
    ctl_d  = ctl_q;
    if (accept && legal) begin
      a_d   = cmd_a;
      b_d   = cmd_b;
      cin_d = cmd_cin;
      ctl_d = cmd_ctl;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    // push and pop together leave occupancy unchanged
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Drive ALU request fields and the FIFO head; head fields read 0 when empty
  always_comb begin
    alu_a      = a_q;
    alu_b      = b_q;
    alu_cin    = cin_q;
    alu_ctl    = ctl_q;
    rsp_valid  = (cnt_q != '0);
    head       = rsp_valid ? mem_q[rd_q] : '0;
    rsp_result = head.result;
    rsp_carry  = head.carry;
    rsp_zero   = head.zero;
    rsp_ctl    = head.ctl;
    rsp_err    = head.err;
  end

`ifdef ALU_ISSUER_STATS_EN
  logic [7:0] issued_q, issued_d, errors_q, errors_d, stray_q, stray_d;
  logic       stray;

  // alu_valid_out outside WAIT has no outstanding operation to answer
  assign stray = alu_valid_out && (state_q != S_WAIT);

  // Saturating event counters
  always_comb begin
    issued_d = issued_q;
    errors_d = errors_q;
    stray_d  = stray_q;
    if (alu_valid_in && issued_q != 8'hFF)        issued_d = issued_q + 8'd1;
    if (push && push_data.err && errors_q != 8'hFF) errors_d = errors_q + 8'd1;
    if (stray && stray_q != 8'hFF)                stray_d  = stray_q + 8'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q <= '0;
      errors_q <= '0;
      stray_q  <= '0;
    end else begin
      issued_q <= issued_d;
      errors_q <= errors_d;
      stray_q  <= stray_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_errors = errors_q;
  assign stat_stray  = stray_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer (FIFO_DEPTH=4, TIMEOUT=4). The ALU is
// played by hand: each step drives alu_valid_out/result explicitly.
module tb_alu_cmd_issuer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_cin;
  logic [3:0] cmd_a, cmd_b, cmd_ctl;
  logic       alu_valid_in, alu_cin;
  logic [3:0] alu_a, alu_b, alu_ctl;
  logic       alu_valid_out, alu_carry, alu_zero;
  logic [3:0] alu_result;
  logic       rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err;
  logic [3:0] rsp_result, rsp_ctl;
  logic       busy;
`ifdef ALU_ISSUER_STATS_EN
  logic [7:0] stat_issued, stat_errors, stat_stray;
`endif

  int checks = 0;
  int errors = 0;

  alu_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_ctl(cmd_ctl),
    .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_ctl(alu_ctl),
    .alu_valid_out(alu_valid_out), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_ctl(rsp_ctl), .busy(busy)
`ifdef ALU_ISSUER_STATS_EN
    , .stat_issued(stat_issued), .stat_errors(stat_errors), .stat_stray(stat_stray)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [3:0] res, input logic c,
                         input logic z, input logic [3:0] ctl, input logic e);
    chk({tag, ".valid"},  {7'd0, rsp_valid}, 8'd1);
    chk({tag, ".result"}, {4'd0, rsp_result}, {4'd0, res});
    chk({tag, ".carry"},  {7'd0, rsp_carry}, {7'd0, c});
    chk({tag, ".zero"},   {7'd0, rsp_zero}, {7'd0, z});
    chk({tag, ".ctl"},    {4'd0, rsp_ctl}, {4'd0, ctl});
    chk({tag, ".err"},    {7'd0, rsp_err}, {7'd0, e});
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // one legal op with the ALU answering in the first WAIT cycle; ends back in IDLE
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ctl, input logic [3:0] res);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_cin = 1'b0; cmd_ctl = ctl;
    step();
    cmd_valid = 1'b0;
    step();
    alu_valid_out = 1'b1; alu_result = res; alu_carry = 1'b0; alu_zero = 1'b0;
    step();
    alu_valid_out = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_ctl = '0;
    alu_valid_out = 1'b0; alu_result = '0; alu_carry = 1'b0; alu_zero = 1'b0;
    rsp_ready = 1'b0;

    // reset state
    step(); step();
    chk("rst.cmd_ready", {7'd0, cmd_ready}, 8'd0);
    chk("rst.busy", {7'd0, busy}, 8'd0);
    chk("rst.rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst.alu_valid_in", {7'd0, alu_valid_in}, 8'd0);
    chk("rst.alu_a", {4'd0, alu_a}, 8'd0);
    #2 reset = 1'b1;
    step();
    chk("rel.cmd_ready", {7'd0, cmd_ready}, 8'd1);

    // 3 + 5 ADD: accept at edge N, issue in N+1, response visible in N+3
    cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd5; cmd_cin = 1'b0; cmd_ctl = 4'd3;
    step();
    cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0;
    chk("add.issue", {7'd0, alu_valid_in}, 8'd1);
    chk("add.alu_a", {4'd0, alu_a}, 8'd3);
    chk("add.alu_b", {4'd0, alu_b}, 8'd5);
    chk("add.alu_ctl", {4'd0, alu_ctl}, 8'd3);
    chk("add.busy", {7'd0, busy}, 8'd1);
    chk("add.cmd_ready", {7'd0, cmd_ready}, 8'd0);
    step();
    chk("add.single_pulse", {7'd0, alu_valid_in}, 8'd0);
    chk("add.hold_a", {4'd0, alu_a}, 8'd3);
    chk("add.no_rsp_yet", {7'd0, rsp_valid}, 8'd0);
    alu_valid_out = 1'b1; alu_result = 4'd8; alu_carry = 1'b0; alu_zero = 1'b0;
    step();
    alu_valid_out = 1'b0;
    chk_rsp("add.rsp", 4'd8, 1'b0, 1'b0, 4'd3, 1'b0);
    chk("add.busy_done", {7'd0, busy}, 8'd0);
    pop_one();
    chk("add.popped", {7'd0, rsp_valid}, 8'd0);

    // 15 + 1 wraps: result 0 with carry and zero
    cmd_valid = 1'b1; cmd_a = 4'd15; cmd_b = 4'd1; cmd_ctl = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    alu_valid_out = 1'b1; alu_result = 4'd0; alu_carry = 1'b1; alu_zero = 1'b1;
    step();
    alu_valid_out = 1'b0;
    chk_rsp("wrap.rsp", 4'd0, 1'b1, 1'b1, 4'd3, 1'b0);
    pop_one();

    // illegal opcode 14: no ALU strobe, error response one cycle after accept
    cmd_valid = 1'b1; cmd_a = 4'd7; cmd_b = 4'd2; cmd_ctl = 4'd14;
    step();
    cmd_valid = 1'b0;
    chk("ill.no_issue", {7'd0, alu_valid_in}, 8'd0);
    chk("ill.busy", {7'd0, busy}, 8'd0);
    chk("ill.cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("ill.alu_a_kept", {4'd0, alu_a}, 8'd15);
    chk_rsp("ill.rsp", 4'd0, 1'b0, 1'b0, 4'd14, 1'b1);
    pop_one();

    // timeout: stray alu_valid_out during ISSUE is ignored, then ALU stays silent
    cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd1; cmd_ctl = 4'd0;
    step();
    cmd_valid = 1'b0;
    alu_valid_out = 1'b1; alu_result = 4'd9;
    step();
    alu_valid_out = 1'b0;
    chk("tmo.ignored_in_issue", {7'd0, rsp_valid}, 8'd0);
    step(); step(); step();
    chk("tmo.busy_wait4", {7'd0, busy}, 8'd1);
    chk("tmo.no_rsp_wait4", {7'd0, rsp_valid}, 8'd0);
    step();
    chk("tmo.busy_drop", {7'd0, busy}, 8'd0);
    chk_rsp("tmo.rsp", 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    pop_one();

    // FIFO full: four buffered responses block the fifth command until one pop
    for (int i = 1; i <= 4; i++) run_op(4'(i), 4'd1, 4'd3, 4'(i + 1));
    chk("full.cmd_ready", {7'd0, cmd_ready}, 8'd0);
    cmd_valid = 1'b1; cmd_a = 4'd5; cmd_b = 4'd1; cmd_ctl = 4'd3;
    step();
    chk("full.not_accepted", {7'd0, busy}, 8'd0);
    chk("full.no_issue", {7'd0, alu_valid_in}, 8'd0);
    chk("full.head1", {4'd0, rsp_result}, 8'd2);
    pop_one();
    chk("full.ready_after_pop", {7'd0, cmd_ready}, 8'd1);
    chk("full.head2", {4'd0, rsp_result}, 8'd3);
    run_op(4'd5, 4'd1, 4'd3, 4'd6);
    chk("full.again", {7'd0, cmd_ready}, 8'd0);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("order.%0d", i), {4'd0, rsp_result}, 8'(i + 1));
      pop_one();
    end
    chk("order.empty", {7'd0, rsp_valid}, 8'd0);

    // reset during WAIT, then a late ALU answer after release
    cmd_valid = 1'b1; cmd_a = 4'd2; cmd_b = 4'd2; cmd_ctl = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid.busy_wait", {7'd0, busy}, 8'd1);
    reset = 1'b0;
    #2;
    chk("mid.rst_busy", {7'd0, busy}, 8'd0);
    chk("mid.rst_ready", {7'd0, cmd_ready}, 8'd0);
    #2 reset = 1'b1;
    step();
    alu_valid_out = 1'b1; alu_result = 4'd4;
    step();
    alu_valid_out = 1'b0;
    step();
    chk("mid.rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("mid.busy", {7'd0, busy}, 8'd0);
    chk("mid.cmd_ready", {7'd0, cmd_ready}, 8'd1);
`ifdef ALU_ISSUER_STATS_EN
    chk("stat.stray", stat_stray, 8'd1);
    chk("stat.issued", stat_issued, 8'd0);
    chk("stat.errors", stat_errors, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
